forward_hazard_ctrl: RTL and testbench
======================================

// Module: forward_hazard_ctrl
// PURPOSE
// - Control side of EX-stage operand forwarding: generates ForwardA/ForwardB select codes for the operand muxes.
// - Tracks rd/regwrite/memread of in-flight instrs in a shadow ID/EX, EX/MEM, MEM/WB pipe fed from decode.
// - Detects load-use hazards (1-cycle stall + bubble) and taken-branch flushes; counts both events.
// PARAMETERS
// - REG_ADDR_W  5   register index width (x0..x31)
// - CNT_W       32  width of stall/flush event counters (saturating)
// PORTS
// - clk             in   1        core clock, rising edge
// - rst_n           in   1        async active-low reset
// - id_valid        in   1        decode stage holds a real instr
// - id_rs1          in   REG_ADDR_W  decode source 1
// - id_rs2          in   REG_ADDR_W  decode source 2
// - id_rd           in   REG_ADDR_W  decode destination
// - id_regwrite     in   1        decode instr writes rd
// - id_memread      in   1        decode instr is a load
// - ex_branch_taken in   1        branch/jump resolved taken in EX this cycle
// - ForwardA        out  2        EX operand A select: 00 regfile, 01 writeback, 10 EX/MEM
// - ForwardB        out  2        EX operand B select, same encoding
// - stall           out  1        hold PC and IF/ID this cycle
// - flush_if_id     out  1        zero IF/ID on next edge
// - bubble_id_ex    out  1        load NOP into ID/EX on next edge
// - stall_count     out  CNT_W    load-use stalls since reset, saturates at all-ones
// - flush_count     out  CNT_W    taken-branch flushes since reset, saturates
// BEHAVIOUR
// - Reset (async, rst_n=0): shadow regs ex_*/mem_*/wb_* cleared (valid=0, rd=0); counters 0;
//   ForwardA/B=00, stall=0, flush_if_id=0, bubble_id_ex=0 while reset asserted and first cycle after.
// - Shadow pipe per edge: ID/EX <= {id_valid,rs1,rs2,rd,regwrite,memread} unless bubble_id_ex (then all 0);
//   EX/MEM <= ID/EX fields; MEM/WB <= EX/MEM fields. Always advances (no back-pressure beyond stall).
// - Forwarding (combinational from shadow regs, applied to instr currently in EX):
//   ForwardA=10 if mem_valid&mem_regwrite&mem_rd!=0&mem_rd==ex_rs1;
//   else 01 if wb_valid&wb_regwrite&wb_rd!=0&wb_rd==ex_rs1; else 00. ForwardB identical on ex_rs2.
//   EX/MEM wins over MEM/WB when both match. x0 never forwarded. Code 11 never driven.
//   Invalid EX instr (ex_valid=0) -> both 00.
// - Load-use: hazard = ex_valid&ex_memread&ex_rd!=0&id_valid&(ex_rd==id_rs1|ex_rd==id_rs2).
//   hazard -> stall=1, bubble_id_ex=1 same cycle; exactly one cycle (next cycle the load is in EX/MEM,
//   handled by ForwardX=01 after it reaches MEM/WB; no re-stall since ID/EX now holds bubble).
// - Branch: ex_branch_taken=1 -> flush_if_id=1, bubble_id_ex=1, stall=0 (redirect beats stall).
//   Simultaneous hazard+branch: branch wins, stall=0, only flush counted.
// - Counters: stall_count +1 per cycle stall=1; flush_count +1 per cycle flush_if_id=1; hold at 2^CNT_W-1.
// - Reset mid-operation: all shadow state dropped immediately; no pending stall/flush survives reset.
// TESTING
// - add x5 then add x6,x5,x1 back-to-back -> EX of 2nd: ForwardA=10, ForwardB=00, stall=0.
// - add x5; nop; sub x7,x1,x5 -> EX of sub: ForwardB=01, ForwardA=00.
// - ld x5; add x6,x5,x5 -> one cycle stall=1,bubble_id_ex=1; stall_count=1; then ForwardA=ForwardB=01.
// - writes to x0 (rd=0) followed by use of x0 -> ForwardA/B stay 00, no stall.
// - ld x5 + dependent in ID while ex_branch_taken=1 -> flush_if_id=1, stall=0, flush_count=1, stall_count=0.
// - CNT_W=2, 5 load-use events -> stall_count 1,2,3,3,3; assert rst_n=0 mid-stall -> all outputs 0 async.

Source files
------------

// File: rtl/forward_hazard_ctrl.sv
// forward_hazard_ctrl
//   Control side of EX-stage operand forwarding for a 5-stage in-order core.
//   A shadow ID/EX -> EX/MEM -> MEM/WB pipe tracks the destination/write/load
//   state of in-flight instructions. From that it derives the operand mux
//   selects, load-use stalls and taken-branch flushes, and it counts both
//   event types.
// Ports
//   clk, rst_n                  rising-edge clock, async active-low reset
//   id_valid/rs1/rs2/rd         instruction currently in decode
//   id_regwrite, id_memread     decode instruction writes rd / is a load
//   ex_branch_taken             branch/jump in EX resolved taken
//   ForwardA, ForwardB          00 regfile, 01 MEM/WB, 10 EX/MEM (11 unused)
//   stall                       hold PC and IF/ID
//   flush_if_id                 zero IF/ID on next edge
//   bubble_id_ex                load NOP into ID/EX on next edge
//   stall_count, flush_count    saturating event counters
module forward_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  ex_branch_taken,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  bubble_id_ex,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } ex_t;

  // Later stages only need what forwarding looks at.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } wr_t;

  ex_t  ex_s;
  wr_t  mem_s, wb_s;
  logic live;   // low during reset and up to the first edge after it
  logic hazard;
  logic mem_fwd_ok, wb_fwd_ok;

  // Shadow pipe: always advances; a bubble replaces the decode instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_s  <= '0;
      mem_s <= '0;
      wb_s  <= '0;
      live  <= 1'b0;
    end else begin
      live <= 1'b1;
      if (bubble_id_ex) ex_s <= '0;
      else              ex_s <= '{id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread};
      mem_s <= '{ex_s.valid, ex_s.rd, ex_s.regwrite};
      wb_s  <= '{mem_s.valid, mem_s.rd, mem_s.regwrite};
    end
  end

  // Producers that may forward: valid, writing, and not targeting x0.
  assign mem_fwd_ok = mem_s.valid && mem_s.regwrite && (mem_s.rd != '0);
  assign wb_fwd_ok  = wb_s.valid  && wb_s.regwrite  && (wb_s.rd  != '0);

  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (ex_s.valid) begin
      // Nearer producer (EX/MEM) holds the newer value, so it is checked first.
      if      (mem_fwd_ok && mem_s.rd == ex_s.rs1) ForwardA = 2'b10;
      else if (wb_fwd_ok  && wb_s.rd  == ex_s.rs1) ForwardA = 2'b01;
      if      (mem_fwd_ok && mem_s.rd == ex_s.rs2) ForwardB = 2'b10;
      else if (wb_fwd_ok  && wb_s.rd  == ex_s.rs2) ForwardB = 2'b01;
    end
  end

  assign hazard = ex_s.valid && ex_s.memread && (ex_s.rd != '0) && id_valid &&
                  ((ex_s.rd == id_rs1) || (ex_s.rd == id_rs2));

  // A taken branch squashes the dependent instruction anyway, so it overrides the stall.
  assign flush_if_id  = live && ex_branch_taken;
  assign stall        = hazard && !flush_if_id;
  assign bubble_id_ex = hazard || flush_if_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && stall_count != '1)       stall_count <= stall_count + 1'b1;
      if (flush_if_id && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
module tb_forward_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_regwrite, id_memread, ex_branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fa, fb, fa2, fb2;
  logic       st, fl, bb, st2, fl2, bb2;
  logic [31:0] sc, fc;
  logic [1:0]  sc2, fc2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  forward_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .ForwardA(fa), .ForwardB(fb), .stall(st),
    .flush_if_id(fl), .bubble_id_ex(bb), .stall_count(sc), .flush_count(fc));

  forward_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .ForwardA(fa2), .ForwardB(fb2), .stall(st2),
    .flush_if_id(fl2), .bubble_id_ex(bb2), .stall_count(sc2), .flush_count(fc2));

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr, br;
    logic [1:0] fa, fb;
    logic       st, fl, bb;
    int         sc, fc;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic v, int rs1, int rs2, int rd, logic rw, logic mr, logic br,
                              int efa, int efb, logic est, logic efl, logic ebb, int esc, int efc);
    vec_t r;
    r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
    r.rw = rw; r.mr = mr; r.br = br;
    r.fa = 2'(efa); r.fb = 2'(efb); r.st = est; r.fl = efl; r.bb = ebb;
    r.sc = esc; r.fc = efc;
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(logic v, int rs1, int rs2, int rd, logic rw, logic mr, logic br);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_regwrite = rw; id_memread = mr; ex_branch_taken = br;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, " FA"}, fa, 0);
    chk({tag, " FB"}, fb, 0);
    chk({tag, " stall"}, st, 0);
    chk({tag, " flush"}, fl, 0);
    chk({tag, " bubble"}, bb, 0);
    chk({tag, " stall_count"}, sc, 0);
    chk({tag, " flush_count"}, fc, 0);
    chk({tag, " stall_count2"}, sc2, 0);
  endtask

  initial begin
    // Each row is one decode cycle; expectations reflect what sits in EX/MEM/WB then.
    //            v  rs1 rs2 rd rw mr br   FA FB st fl bb sc fc
    vecs[0]  = mk(1, 1, 2, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0); // add x5,x1,x2
    vecs[1]  = mk(1, 5, 1, 6, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0); // add x6,x5,x1
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0); // EX/MEM fwd on A
    vecs[3]  = mk(1, 3, 4, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0); // add x5,x3,x4
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 5, 7, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0); // sub x7,x1,x5
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0); // MEM/WB fwd on B
    vecs[7]  = mk(1, 1, 1, 8, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0); // add x8,x1,x1
    vecs[8]  = mk(1, 2, 2, 8, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0); // add x8,x2,x2
    vecs[9]  = mk(1, 8, 8, 9, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0); // add x9,x8,x8
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0,   2, 2, 0, 0, 0, 0, 0); // newer x8 wins
    vecs[11] = mk(1, 1, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0); // add x0,x1,x1
    vecs[12] = mk(1, 0, 0, 3, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0); // add x3,x0,x0
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0); // x0 not forwarded
    vecs[14] = mk(1, 1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0); // ld x0
    vecs[15] = mk(1, 0, 0, 4, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0); // use x0: no stall
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(1, 1, 0, 5, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0); // ld x5
    vecs[18] = mk(1, 5, 5, 6, 1, 0, 0,   0, 0, 1, 0, 1, 0, 0); // add x6,x5,x5 stalls
    vecs[19] = mk(1, 5, 5, 6, 1, 0, 0,   0, 0, 0, 0, 0, 1, 0); // held, bubble in EX
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 0); // load via MEM/WB
    vecs[21] = mk(1, 1, 0, 5, 1, 1, 0,   0, 0, 0, 0, 0, 1, 0); // ld x5
    vecs[22] = mk(1, 1, 5, 6, 1, 0, 1,   0, 0, 0, 1, 1, 1, 0); // dep + branch taken
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1);

    // Reset with a pending branch request: everything must stay quiet.
    rst_n = 1'b0;
    drive(0, 5, 5, 5, 1, 1, 1);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    #2;
    chk("post-reset flush", fl, 0);
    chk("post-reset stall", st, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].br);
      #2;
      chk($sformatf("r%0d FA", i), fa, vecs[i].fa);
      chk($sformatf("r%0d FB", i), fb, vecs[i].fb);
      chk($sformatf("r%0d stall", i), st, vecs[i].st);
      chk($sformatf("r%0d flush", i), fl, vecs[i].fl);
      chk($sformatf("r%0d bubble", i), bb, vecs[i].bb);
      chk($sformatf("r%0d stall_count", i), sc, vecs[i].sc);
      chk($sformatf("r%0d flush_count", i), fc, vecs[i].fc);
    end

    // Saturation on the 2-bit counter: five load-use stalls (rs2 dependency).
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1, 1, 0, 5, 1, 1, 0);          // ld x5
      @(negedge clk);
      drive(1, 1, 5, 6, 1, 0, 0);          // add x6,x1,x5
      #2;
      chk($sformatf("sat%0d stall", k), st, 1);
      @(negedge clk);                       // held instr, bubble now in EX
      #2;
      chk($sformatf("sat%0d no re-stall", k), st, 0);
      chk($sformatf("sat%0d stall_count", k), sc, k + 1);
      chk($sformatf("sat%0d stall_count2", k), sc2, (k + 1 > 3) ? 3 : k + 1);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
    end

    // Reset in the middle of a stall (rs1 dependency) clears everything at once.
    @(negedge clk);
    drive(1, 1, 0, 5, 1, 1, 0);            // ld x5
    @(negedge clk);
    drive(1, 5, 1, 6, 1, 0, 0);            // add x6,x5,x1
    #2;
    chk("midrst stall before", st, 1);
    chk("midrst bubble before", bb, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    ex_branch_taken = 1'b1;
    #1;
    chk("midrst flush w/ branch", fl, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("after midrst stall", st, 0);
    chk("after midrst stall_count", sc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
